reservation_station: RTL and testbench

RESERVATION_STATION -- requirements
Module: reservation_station

---
 rtl/reservation_station.sv | 150 +++++++++++++++
 tb/tb_reservation_station.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// reservation_station: Tomasulo-style station for ADD/SUB with register status table,
// CDB wakeup/bypass and in-order lowest-index dispatch to one functional unit.
module reservation_station #(
    parameter int NENT = 3,
    parameter int DW   = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [2:0]    opcode,
    input  logic [2:0]    RX,
    input  logic [2:0]    RY,
    input  logic [2:0]    RZ,
    input  logic [3:0]    immediate,
    output logic          stall,
    output logic [2:0]    rf_addr_a,
    output logic [2:0]    rf_addr_b,
    input  logic [DW-1:0] rf_data_a,
    input  logic [DW-1:0] rf_data_b,
    input  logic          cdb_valid,
    input  logic [1:0]    cdb_tag,
    input  logic [DW-1:0] cdb_data,
    output logic          disp_valid,
    input  logic          disp_ready,
    output logic [2:0]    disp_op,
    output logic [DW-1:0] disp_a,
    output logic [DW-1:0] disp_b,
    output logic [1:0]    disp_tag,
    output logic          illegal_op
);
    localparam logic [1:0] S_EMPTY = 2'd0, S_WAIT = 2'd1, S_READY = 2'd2, S_EXEC = 2'd3;
    localparam int IW = (NENT > 1) ? $clog2(NENT) : 1;

    logic [1:0]    r_state [NENT];
    logic [2:0]    r_op    [NENT];
    logic [DW-1:0] r_vj    [NENT];
    logic [DW-1:0] r_vk    [NENT];
    logic [1:0]    r_qj    [NENT];
    logic [1:0]    r_qk    [NENT];
    logic [1:0]    r_qi    [8];
    logic          r_illegal;

    logic          w_free, w_rdy, w_accept, w_legal, w_issue, w_cdb, w_fire;
    logic [IW-1:0] w_alloc, w_sel;
    logic [1:0]    w_new_tag, w_src_j, w_src_k, w_qj_new, w_qk_new;
    logic [DW-1:0] w_vj_new, w_vk_new;
    logic          w_hj [NENT];
    logic          w_hk [NENT];
    logic          w_unused_imm;

    always_comb begin
        w_free  = 1'b0;
        w_alloc = '0;
        w_rdy   = 1'b0;
        w_sel   = '0;
        for (int i = NENT - 1; i >= 0; i--) begin
            if (r_state[i] == S_EMPTY) begin
                w_free  = 1'b1;
                w_alloc = IW'(i);
            end
            if (r_state[i] == S_READY) begin
                w_rdy = 1'b1;
                w_sel = IW'(i);
            end
        end
    end

    // tag 0 on the CDB never matches anything: it is the "value present" encoding
    assign w_cdb     = cdb_valid && (cdb_tag != 2'd0);
    assign w_accept  = in_valid && w_free;
    assign w_legal   = (opcode[2:1] == 2'b00);
    assign w_issue   = w_accept && w_legal;
    assign w_new_tag = 2'(w_alloc) + 2'd1;
    assign w_fire    = w_rdy && disp_ready;

    // operand lookup sees Qi before this instruction's own RX update, with same-edge CDB bypass
    assign w_src_j  = r_qi[RY];
    assign w_src_k  = r_qi[RZ];
    assign w_qj_new = (w_src_j == 2'd0 || (w_cdb && cdb_tag == w_src_j)) ? 2'd0 : w_src_j;
    assign w_qk_new = (w_src_k == 2'd0 || (w_cdb && cdb_tag == w_src_k)) ? 2'd0 : w_src_k;
    assign w_vj_new = (w_src_j == 2'd0) ? rf_data_a : (w_qj_new == 2'd0 ? cdb_data : '0);
    assign w_vk_new = (w_src_k == 2'd0) ? rf_data_b : (w_qk_new == 2'd0 ? cdb_data : '0);

    always_comb begin
        for (int i = 0; i < NENT; i++) begin
            w_hj[i] = w_cdb && (r_qj[i] == cdb_tag);
            w_hk[i] = w_cdb && (r_qk[i] == cdb_tag);
        end
    end

    assign stall        = !w_free;
    assign rf_addr_a    = RY;
    assign rf_addr_b    = RZ;
    assign disp_valid   = w_rdy;
    assign disp_op      = r_op[w_sel];
    assign disp_a       = r_vj[w_sel];
    assign disp_b       = r_vk[w_sel];
    assign disp_tag     = 2'(w_sel) + 2'd1;
    assign illegal_op   = r_illegal;
    assign w_unused_imm = |immediate;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_illegal <= 1'b0;
            for (int r = 0; r < 8; r++) r_qi[r] <= 2'd0;
            for (int i = 0; i < NENT; i++) begin
                r_state[i] <= S_EMPTY;
                r_op[i]    <= 3'd0;
                r_vj[i]    <= '0;
                r_vk[i]    <= '0;
                r_qj[i]    <= 2'd0;
                r_qk[i]    <= 2'd0;
            end
        end else begin
            r_illegal <= w_accept && !w_legal;
            // a same-edge issue to RX takes priority over the CDB clearing its status
            for (int r = 0; r < 8; r++) begin
                if (w_issue && RX == 3'(r))
                    r_qi[r] <= w_new_tag;
                else if (w_cdb && r_qi[r] == cdb_tag)
                    r_qi[r] <= 2'd0;
            end
            for (int i = 0; i < NENT; i++) begin
                if (r_state[i] == S_EMPTY && w_issue && w_alloc == IW'(i)) begin
                    r_op[i]    <= opcode;
                    r_vj[i]    <= w_vj_new;
                    r_vk[i]    <= w_vk_new;
                    r_qj[i]    <= w_qj_new;
                    r_qk[i]    <= w_qk_new;
                    r_state[i] <= (w_qj_new == 2'd0 && w_qk_new == 2'd0) ? S_READY : S_WAIT;
                end else if (r_state[i] == S_WAIT) begin
                    if (w_hj[i]) begin
                        r_vj[i] <= cdb_data;
                        r_qj[i] <= 2'd0;
                    end
                    if (w_hk[i]) begin
                        r_vk[i] <= cdb_data;
                        r_qk[i] <= 2'd0;
                    end
                    if ((w_hj[i] || r_qj[i] == 2'd0) && (w_hk[i] || r_qk[i] == 2'd0))
                        r_state[i] <= S_READY;
                end else if (r_state[i] == S_READY && w_fire && w_sel == IW'(i)) begin
                    r_state[i] <= S_EXEC;
                end else if (r_state[i] == S_EXEC && w_cdb && cdb_tag == 2'(i + 1)) begin
                    r_state[i] <= S_EMPTY;
                end
            end
        end
    end
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed issue/wakeup/full/bypass/illegal/reset sequence
// observed entirely through the station's ports.
module tb_reservation_station;
    logic        clock, reset, in_valid, stall, cdb_valid, disp_valid, disp_ready, illegal_op;
    logic [2:0]  opcode, RX, RY, RZ, rf_addr_a, rf_addr_b, disp_op;
    logic [3:0]  immediate;
    logic [15:0] rf_data_a, rf_data_b, cdb_data, disp_a, disp_b;
    logic [1:0]  cdb_tag, disp_tag;
    int          checks = 0;
    int          errors = 0;

    reservation_station #(.NENT(3), .DW(16)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .opcode(opcode),
        .RX(RX), .RY(RY), .RZ(RZ), .immediate(immediate), .stall(stall),
        .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
        .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_a(disp_a), .disp_b(disp_b), .disp_tag(disp_tag), .illegal_op(illegal_op)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry,
                         input logic [2:0] rz, input logic [15:0] a, input logic [15:0] b);
        in_valid = 1'b1; opcode = op; RX = rx; RY = ry; RZ = rz;
        rf_data_a = a; rf_data_b = b; immediate = 4'hF;
    endtask

    task automatic cdb(input logic [1:0] t, input logic [15:0] d);
        cdb_valid = 1'b1; cdb_tag = t; cdb_data = d;
    endtask

    initial begin
        reset = 1'b0; disp_ready = 1'b0; cdb_valid = 1'b0; cdb_tag = 2'd0; cdb_data = '0;
        issue(3'd0, 3'd0, 3'd1, 3'd2, 16'h1, 16'h2);
        tick(); tick();
        chk("rst_stall", stall, 0);
        chk("rst_disp_valid", disp_valid, 0);
        chk("rst_illegal", illegal_op, 0);
        in_valid = 1'b0;
        reset = 1'b1;
        // simple issue: ADD R0,R1,R2
        issue(3'd0, 3'd0, 3'd1, 3'd2, 16'd5, 16'd7);
        #1;
        chk("rf_addr_a", rf_addr_a, 1);
        chk("rf_addr_b", rf_addr_b, 2);
        tick(); in_valid = 1'b0;
        chk("t1_disp_valid", disp_valid, 1);
        chk("t1_disp_a", disp_a, 5);
        chk("t1_disp_b", disp_b, 7);
        chk("t1_disp_tag", disp_tag, 1);
        chk("t1_disp_op", disp_op, 0);
        // SUB R1,R0,R1 waits on tag 1
        issue(3'd1, 3'd1, 3'd0, 3'd1, 16'h99, 16'd3);
        tick(); in_valid = 1'b0;
        chk("dep_head_tag", disp_tag, 1);
        disp_ready = 1'b1; tick(); disp_ready = 1'b0;
        chk("dep_waiting", disp_valid, 0);
        cdb(2'd1, 16'd12); tick(); cdb_valid = 1'b0;
        chk("wake_valid", disp_valid, 1);
        chk("wake_tag", disp_tag, 2);
        chk("wake_a", disp_a, 12);
        chk("wake_b", disp_b, 3);
        chk("wake_op", disp_op, 1);
        // Qi[0] cleared -> rf value; Qi[1]=2 -> waits
        issue(3'd0, 3'd2, 3'd0, 3'd1, 16'h44, 16'h55);
        tick(); in_valid = 1'b0;
        disp_ready = 1'b1; tick(); disp_ready = 1'b0;
        chk("qi1_waiting", disp_valid, 0);
        // same-edge bypass of tag 2 into a fresh issue
        cdb(2'd2, 16'hBEEF);
        issue(3'd0, 3'd3, 3'd1, 3'd4, 16'h1111, 16'd6);
        tick(); in_valid = 1'b0; cdb_valid = 1'b0;
        chk("byp_e0_tag", disp_tag, 1);
        chk("byp_e0_a", disp_a, 16'h44);
        chk("byp_e0_b", disp_b, 16'hBEEF);
        disp_ready = 1'b1; tick(); disp_ready = 1'b0;
        chk("byp_new_tag", disp_tag, 3);
        chk("byp_new_a", disp_a, 16'hBEEF);
        chk("byp_new_b", disp_b, 6);
        // fill the station
        issue(3'd0, 3'd5, 3'd2, 3'd3, 16'h0, 16'h0);
        tick(); in_valid = 1'b0;
        chk("full_stall", stall, 1);
        issue(3'd0, 3'd6, 3'd0, 3'd0, 16'h77, 16'h77);
        #1;
        chk("full_stall_hold", stall, 1);
        tick(); in_valid = 1'b0;
        disp_ready = 1'b1; tick(); disp_ready = 1'b0;
        chk("full_no_ready", disp_valid, 0);
        cdb(2'd1, 16'h1234);
        #1;
        chk("free_same_cycle_stall", stall, 1);
        tick(); cdb_valid = 1'b0;
        chk("freed_stall", stall, 0);
        chk("freed_disp_valid", disp_valid, 0);
        cdb(2'd3, 16'h0033); tick(); cdb_valid = 1'b0;
        chk("full_wake_tag", disp_tag, 2);
        chk("full_wake_a", disp_a, 16'h1234);
        chk("full_wake_b", disp_b, 16'h0033);
        // Qi[6] must be untouched by the rejected 4th instruction
        issue(3'd1, 3'd7, 3'd6, 3'd5, 16'h66, 16'h55);
        tick(); in_valid = 1'b0;
        disp_ready = 1'b1; tick(); disp_ready = 1'b0;
        chk("rej_wait_qk", disp_valid, 0);
        cdb(2'd2, 16'h0505); tick(); cdb_valid = 1'b0;
        chk("rej_tag", disp_tag, 1);
        chk("rej_a", disp_a, 16'h66);
        chk("rej_b", disp_b, 16'h0505);
        chk("rej_op", disp_op, 1);
        // illegal opcode
        issue(3'd2, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0);
        #1;
        chk("ill_before", illegal_op, 0);
        tick(); in_valid = 1'b0;
        chk("ill_pulse", illegal_op, 1);
        tick();
        chk("ill_end", illegal_op, 0);
        issue(3'd0, 3'd1, 3'd0, 3'd0, 16'd8, 16'd9);
        disp_ready = 1'b1;
        tick(); in_valid = 1'b0; disp_ready = 1'b0;
        chk("ill_noalloc_tag", disp_tag, 2);
        chk("ill_noalloc_a", disp_a, 8);
        chk("ill_noalloc_b", disp_b, 9);
        // reset mid-operation
        issue(3'd0, 3'd4, 3'd0, 3'd0, 16'h1, 16'h2);
        tick(); in_valid = 1'b0;
        chk("pre_rst_stall", stall, 1);
        #3 reset = 1'b0;
        #1;
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_disp_valid", disp_valid, 0);
        tick(); reset = 1'b1;
        issue(3'd0, 3'd0, 3'd1, 3'd4, 16'h21, 16'h22);
        tick(); in_valid = 1'b0;
        chk("post_rst_valid", disp_valid, 1);
        chk("post_rst_tag", disp_tag, 1);
        chk("post_rst_a", disp_a, 16'h21);
        chk("post_rst_b", disp_b, 16'h22);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
